// File: rtl/subterranean_pkg.sv
// Shared constants, operation/FSM encodings and duplex bit-position helper
// for the Subterranean duplex datapath.
package subterranean_pkg;

   localparam int SUBT_STATE_W    = 257;
   localparam int SUBT_LANE_W     = 32;
   localparam int SUBT_LANE_PAD_W = 33;

   typedef enum logic [1:0] {
      OPER_ABSORB  = 2'b00,
      OPER_SQUEEZE = 2'b01,
      OPER_ENC     = 2'b10,
      OPER_DEC     = 2'b11
   } subt_oper_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BLANK = 1'b1
   } subt_fsm_t;

   // Duplex bit j is injected at (and extracted around) state position 12^(4j) mod 257.
   function automatic int subt_pos(input int j);
      int p;
      p = 1;
      for (int k = 0; k < 4 * j; k++) begin
         p = (p * 12) % SUBT_STATE_W;
      end
      return p;
   endfunction

endpackage

// File: rtl/subterranean_lane_pad.sv
// Per-lane keystream xor, partial-lane byte mask and 33-bit padding; blank
// rounds override the lane input with the empty-block padding 33'h1.
module subterranean_lane_pad
   import subterranean_pkg::*;
(
   input  subt_oper_t                 oper,
   input  logic                       blank,
   input  logic [SUBT_LANE_W-1:0]     din_lane,
   input  logic [2:0]                 size,
   input  logic [SUBT_LANE_W-1:0]     round_dout,
   output logic [SUBT_LANE_PAD_W-1:0] pad_in,
   output logic [SUBT_LANE_W-1:0]     dout_lane
);

   logic [SUBT_LANE_W-1:0] mask;
   logic [SUBT_LANE_W-1:0] xo;
   logic [SUBT_LANE_W-1:0] x;

   always_comb begin
      mask = '1;
      if ((oper == OPER_ENC || oper == OPER_DEC) && size < 3'd4) begin
         mask = (SUBT_LANE_W'(1) << {size[1:0], 3'b000}) - SUBT_LANE_W'(1);
      end
      xo     = (round_dout ^ din_lane) & mask;
      x      = (oper == OPER_DEC) ? xo : din_lane;
      pad_in = {1'b0, x};
      // Sizes 5..7 are raw 32-bit absorbs without a pad bit.
      if (size <= 3'd4) begin
         pad_in = pad_in ^ (SUBT_LANE_PAD_W'(1) << {size, 3'b000});
      end
      if (blank) begin
         pad_in = SUBT_LANE_PAD_W'(1);
      end
      dout_lane = xo;
   end

endmodule

// File: rtl/subterranean_round.sv
// One Subterranean duplex round: extract keystream from the incoming state,
// then chi/iota/theta/pi and injection of the 33-bit padded lane input.
module subterranean_round
   import subterranean_pkg::*;
(
   input  logic [SUBT_STATE_W-1:0]    state_i,
   input  logic [SUBT_LANE_PAD_W-1:0] din_i,
   output logic [SUBT_STATE_W-1:0]    state_o,
   output logic [SUBT_LANE_W-1:0]     dout_o
);

   logic [SUBT_STATE_W-1:0] chi;
   logic [SUBT_STATE_W-1:0] theta;

   always_comb begin
      chi     = '0;
      theta   = '0;
      state_o = '0;
      dout_o  = '0;
      for (int i = 0; i < SUBT_STATE_W; i++) begin
         chi[i] = state_i[i] ^ (~state_i[(i + 1) % SUBT_STATE_W] & state_i[(i + 2) % SUBT_STATE_W]);
      end
      chi[0] = ~chi[0];
      for (int i = 0; i < SUBT_STATE_W; i++) begin
         theta[i] = chi[i] ^ chi[(i + 3) % SUBT_STATE_W] ^ chi[(i + 8) % SUBT_STATE_W];
      end
      for (int i = 0; i < SUBT_STATE_W; i++) begin
         state_o[i] = theta[(12 * i) % SUBT_STATE_W];
      end
      for (int j = 0; j < SUBT_LANE_PAD_W; j++) begin
         state_o[subt_pos(j)] = state_o[subt_pos(j)] ^ din_i[j];
      end
      // Keystream comes from the state before this round's permutation.
      for (int j = 0; j < SUBT_LANE_W; j++) begin
         dout_o[j] = state_i[subt_pos(j)] ^ state_i[SUBT_STATE_W - subt_pos(j)];
      end
   end

endmodule

// File: rtl/subterranean_rounds_param.sv
// LANES chained duplex rounds per clock plus blank-round sequencer; output is one register,
// or a 2-entry FIFO when SUBTERRANEAN_ROUNDS_OUTBUF_EN is defined (din stalls when it is full).
module subterranean_rounds_param
   import subterranean_pkg::*;
#(
   parameter int LANES = 4,
   parameter int ERW   = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic                 clk,
   input  logic                 arstn,
   input  logic                 init,
   input  logic [1:0]           oper,
   input  logic [ERW-1:0]       enable_round,
   input  logic [32*LANES-1:0]  din,
   input  logic [3*LANES-1:0]   din_size,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [7:0]           blank_count,
   input  logic                 blank_valid,
   output logic                 blank_ready,
   output logic [32*LANES-1:0]  dout,
   output logic [3*LANES-1:0]   dout_size,
   output logic                 dout_valid,
   input  logic                 dout_ready
);

   localparam int CW = $clog2(LANES + 1);
`ifdef SUBTERRANEAN_ROUNDS_OUTBUF_EN
   localparam int OB_DEPTH = 2;
`else
   localparam int OB_DEPTH = 1;
`endif

   subt_oper_t                  oper_e;
   subt_fsm_t                   state_q, state_d;
   logic [7:0]                  rem_q, rem_d;
   logic [SUBT_STATE_W-1:0]     reg_state_q, reg_state_d;
   logic [1:0][32*LANES-1:0]    dat_q, dat_d;
   logic [1:0][3*LANES-1:0]     size_q, size_d;
   logic                        wr_q, wr_d, rd_q, rd_d;
   logic [1:0]                  cnt_q, cnt_d;

   logic                        blank_act, din_hs, blank_hs, push, pop, space;
   logic [CW-1:0]               n_din, n_blank, n_sel;
   logic [SUBT_STATE_W-1:0]     last_sel;
   logic [32*LANES-1:0]         out_dat;
   logic [3*LANES-1:0]          out_size;

   assign oper_e    = subt_oper_t'(oper);
   assign blank_act = (state_q == ST_BLANK);
   assign n_din     = CW'(enable_round) + CW'(1);
   assign n_blank   = (rem_q >= 8'(LANES)) ? CW'(LANES) : CW'(rem_q);
   assign n_sel     = blank_act ? n_blank : n_din;

   // Each lane forwards either its own round output or the earlier selection,
   // so the last lane carries the state after exactly n_sel rounds.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [SUBT_STATE_W-1:0]    s_in, s_out, sel, sel_prev;
      logic [SUBT_LANE_PAD_W-1:0] pad_in;
      logic [SUBT_LANE_W-1:0]     rnd_dout, pad_dout;

      if (i == 0) begin : g_first
         assign s_in     = reg_state_q;
         assign sel_prev = reg_state_q;
      end else begin : g_next
         assign s_in     = g_lane[i-1].s_out;
         assign sel_prev = g_lane[i-1].sel;
      end

      subterranean_lane_pad u_pad (
         .oper       (oper_e),
         .blank      (blank_act),
         .din_lane   (din[32*i +: 32]),
         .size       (din_size[3*i +: 3]),
         .round_dout (rnd_dout),
         .pad_in     (pad_in),
         .dout_lane  (pad_dout)
      );

      subterranean_round u_round (
         .state_i (s_in),
         .din_i   (pad_in),
         .state_o (s_out),
         .dout_o  (rnd_dout)
      );

      assign sel                 = (n_sel == CW'(i + 1)) ? s_out : sel_prev;
      assign out_dat[32*i +: 32] = (ERW'(i) <= enable_round) ? pad_dout : '0;
      assign out_size[3*i +: 3]  = (oper_e != OPER_SQUEEZE) ? din_size[3*i +: 3] :
                                   (ERW'(i) == enable_round) ? 3'b100 : 3'b000;
   end

   assign last_sel   = g_lane[LANES-1].sel;
   assign dout_valid = (cnt_q != 2'd0);
   assign pop        = dout_valid && dout_ready;
   assign space      = (cnt_q < 2'(OB_DEPTH)) || pop;
   assign dout       = dat_q[rd_q];
   assign dout_size  = size_q[rd_q];

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      reg_state_d = reg_state_q;
      push        = 1'b0;
      blank_ready = (state_q == ST_IDLE);
      din_ready   = (state_q == ST_IDLE) && !blank_valid && space;
      blank_hs    = blank_valid && blank_ready;
      din_hs      = din_valid && din_ready;
      if (init) begin
         reg_state_d = '0;
         state_d     = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (blank_hs) begin
                  state_d = ST_BLANK;
                  rem_d   = blank_count;
               end else if (din_hs) begin
                  reg_state_d = last_sel;
                  push        = (oper_e != OPER_ABSORB);
               end
            end
            ST_BLANK: begin
               reg_state_d = last_sel;
               rem_d       = rem_q - 8'(n_blank);
               if (rem_d == 8'd0) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      dat_d  = dat_q;
      size_d = size_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (push) begin
         dat_d[wr_q]  = out_dat;
         size_d[wr_q] = out_size;
         wr_d         = (OB_DEPTH == 2) ? ~wr_q : 1'b0;
      end
      if (pop) begin
         rd_d = (OB_DEPTH == 2) ? ~rd_q : 1'b0;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         cnt_q   <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
      end
   end

   // Datapath state and output data are cleared by init, not by reset.
   always_ff @(posedge clk) begin
      reg_state_q <= reg_state_d;
      dat_q       <= dat_d;
   end

endmodule

// File: tb/tb_subterranean_rounds_param.sv
// Directed bench for subterranean_rounds_param (LANES=4) with a reference duplex model.
module tb_subterranean_rounds_param;

   localparam int LANES = 4;
`ifdef SUBTERRANEAN_ROUNDS_OUTBUF_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic         clk = 1'b0;
   logic         arstn, init;
   logic [1:0]   oper;
   logic [1:0]   enable_round;
   logic [127:0] din;
   logic [11:0]  din_size;
   logic         din_valid, din_ready;
   logic [7:0]   blank_count;
   logic         blank_valid, blank_ready;
   logic [127:0] dout;
   logic [11:0]  dout_size;
   logic         dout_valid, dout_ready;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           pos [33];
   logic [256:0] m_state;

   subterranean_rounds_param #(.LANES(LANES)) dut (
      .clk(clk), .arstn(arstn), .init(init), .oper(oper), .enable_round(enable_round),
      .din(din), .din_size(din_size), .din_valid(din_valid), .din_ready(din_ready),
      .blank_count(blank_count), .blank_valid(blank_valid), .blank_ready(blank_ready),
      .dout(dout), .dout_size(dout_size), .dout_valid(dout_valid), .dout_ready(dout_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [256:0] m_round(input logic [256:0] s, input logic [32:0] x);
      logic [256:0] a, b, c;
      for (int i = 0; i < 257; i++) a[i] = s[i] ^ (~s[(i + 1) % 257] & s[(i + 2) % 257]);
      a[0] = ~a[0];
      for (int i = 0; i < 257; i++) b[i] = a[i] ^ a[(i + 3) % 257] ^ a[(i + 8) % 257];
      for (int i = 0; i < 257; i++) c[i] = b[(12 * i) % 257];
      for (int j = 0; j < 33; j++) if (x[j]) c[pos[j]] = ~c[pos[j]];
      return c;
   endfunction

   function automatic logic [31:0] m_extract(input logic [256:0] s);
      logic [31:0] z;
      for (int j = 0; j < 32; j++) z[j] = s[pos[j]] ^ s[257 - pos[j]];
      return z;
   endfunction

   function automatic logic [32:0] m_pad(input logic [31:0] x, input int k);
      logic [32:0] p;
      p = {1'b0, x};
      if (k <= 4) p = p ^ (33'h1 << (8 * k));
      return p;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      arstn = 1'b1;
      step();
      init = 1'b1;
      step();
      init = 1'b0;
      oper = 2'b01; enable_round = 2'd0; din = '0; din_size = '0; din_valid = 1'b1;
      dout_ready = 1'b0;
      step();
      din_valid = 1'b0;
      n_checks++;
      if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", dout_valid); end
      #2 arstn = 1'b0;
      #1;
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid got=%b exp=0", dout_valid); end
      n_checks++;
      if (dout_size !== 12'h000) begin n_fail++; $display("FAIL rst_dout_size got=%h exp=000", dout_size); end
      n_checks++;
      if (din_ready !== 1'b1) begin n_fail++; $display("FAIL rst_din_ready got=%b exp=1", din_ready); end
      n_checks++;
      if (blank_ready !== 1'b1) begin n_fail++; $display("FAIL rst_blank_ready got=%b exp=1", blank_ready); end
      step();
      arstn = 1'b1;
      step();
      n_checks++;
      if ({blank_ready, din_ready, dout_valid} !== 3'b110) begin
         n_fail++; $display("FAIL rst_release got=%b exp=110", {blank_ready, din_ready, dout_valid});
      end
      init = 1'b1;
      step();
      init = 1'b0;
      m_state = '0;
      dout_ready = 1'b1;
   endtask

   task automatic test_blank(input int count, input int exp_cycles);
      int low;
      logic din_seen;
      blank_count = 8'(count); blank_valid = 1'b1;
      #1;
      n_checks++;
      if (din_ready !== 1'b0) begin n_fail++; $display("FAIL blank_prio cnt=%0d got=%b exp=0", count, din_ready); end
      step();
      blank_valid = 1'b0;
      low = 0; din_seen = 1'b0;
      for (int c = 0; c < 12 && blank_ready !== 1'b1; c++) begin
         low++;
         if (din_ready !== 1'b0) din_seen = 1'b1;
         step();
      end
      n_checks++;
      if (low != exp_cycles) begin n_fail++; $display("FAIL blank_cycles cnt=%0d got=%0d exp=%0d", count, low, exp_cycles); end
      n_checks++;
      if (din_seen !== 1'b0) begin n_fail++; $display("FAIL blank_din_ready cnt=%0d got=1 exp=0", count); end
      for (int r = 0; r < count; r++) m_state = m_round(m_state, 33'h1);
      n_checks++;
      if (dut.reg_state_q !== m_state) begin
         n_fail++; $display("FAIL blank_state cnt=%0d got=%h exp=%h", count, dut.reg_state_q, m_state);
      end
   endtask

   task automatic test_encrypt();
      logic [256:0] s;
      logic [127:0] exp_d;
      din = {32'h0F1E2D3C, 32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
      din_size = 12'h924; oper = 2'b10; enable_round = 2'd3; din_valid = 1'b1;
      s = m_state;
      for (int i = 0; i < 4; i++) begin
         exp_d[32*i +: 32] = din[32*i +: 32] ^ m_extract(s);
         s = m_round(s, m_pad(din[32*i +: 32], 4));
      end
      #1;
      n_checks++;
      if (din_ready !== 1'b1) begin n_fail++; $display("FAIL enc_din_ready got=%b exp=1", din_ready); end
      step();
      din_valid = 1'b0;
      m_state = s;
      n_checks++;
      if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL enc_valid got=%b exp=1", dout_valid); end
      n_checks++;
      if (dout !== exp_d) begin n_fail++; $display("FAIL enc_dout got=%h exp=%h", dout, exp_d); end
      n_checks++;
      if (dout_size !== 12'h924) begin n_fail++; $display("FAIL enc_size got=%h exp=924", dout_size); end
      n_checks++;
      if (dut.reg_state_q !== m_state) begin n_fail++; $display("FAIL enc_state got=%h exp=%h", dut.reg_state_q, m_state); end
      step();
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL enc_pop got=%b exp=0", dout_valid); end
   endtask

   task automatic test_decrypt();
      logic [31:0]  xo;
      logic [127:0] exp_d;
      din = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hA5C3_1234};
      din_size = 12'h002; oper = 2'b11; enable_round = 2'd0; din_valid = 1'b1;
      xo = (m_extract(m_state) ^ 32'hA5C3_1234) & 32'h0000_FFFF;
      exp_d = {96'h0, xo};
      m_state = m_round(m_state, {1'b0, xo} ^ 33'h0_0001_0000);
      step();
      din_valid = 1'b0;
      n_checks++;
      if (dout[31:16] !== 16'h0) begin n_fail++; $display("FAIL dec_upper got=%h exp=0000", dout[31:16]); end
      n_checks++;
      if (dout !== exp_d) begin n_fail++; $display("FAIL dec_dout got=%h exp=%h", dout, exp_d); end
      n_checks++;
      if (dout_size !== 12'h002) begin n_fail++; $display("FAIL dec_size got=%h exp=002", dout_size); end
      n_checks++;
      if (dut.reg_state_q !== m_state) begin n_fail++; $display("FAIL dec_state got=%h exp=%h", dut.reg_state_q, m_state); end
      step();
   endtask

   task automatic test_backpressure();
      logic [127:0] exp_q [3];
      logic         exp_rdy;
      logic [31:0]  lane;
      dout_ready = 1'b0; oper = 2'b01; enable_round = 2'd0; din_size = 12'h000;
      for (int k = 0; k < 3; k++) begin
         lane = 32'(32'h1111_1111 * (k + 1));
         din = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, lane};
         din_valid = 1'b1;
         #1;
         exp_rdy = (k < DEPTH);
         n_checks++;
         if (din_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_ready k=%0d got=%b exp=%b", k, din_ready, exp_rdy); end
         if (exp_rdy) begin
            exp_q[k] = {96'h0, m_extract(m_state) ^ lane};
            m_state  = m_round(m_state, m_pad(lane, 0));
         end
         step();
      end
      din_valid = 1'b0;
      n_checks++;
      if (dut.reg_state_q !== m_state) begin n_fail++; $display("FAIL bp_state got=%h exp=%h", dut.reg_state_q, m_state); end
      dout_ready = 1'b1;
      #1;
      n_checks++;
      if (din_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_space got=%b exp=1", din_ready); end
      for (int k = 0; k < DEPTH; k++) begin
         n_checks++;
         if ({dout_valid, dout_size, dout} !== {1'b1, 12'h004, exp_q[k]}) begin
            n_fail++; $display("FAIL bp_entry k=%0d got=%b/%h/%h exp=1/004/%h", k, dout_valid, dout_size, dout, exp_q[k]);
         end
         step();
      end
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b exp=0", dout_valid); end
   endtask

   task automatic test_init_abort();
      logic [127:0] exp_d;
      logic [256:0] s;
      dout_ready = 1'b0; oper = 2'b01; enable_round = 2'd1; din_size = 12'h000;
      din = {64'h0, 32'h0BAD_F00D, 32'h1234_5678};
      exp_d = {64'h0, 32'h0BAD_F00D ^ m_extract(m_round(m_state, m_pad(32'h1234_5678, 0))),
               32'h1234_5678 ^ m_extract(m_state)};
      m_state = m_round(m_state, m_pad(32'h1234_5678, 0));
      m_state = m_round(m_state, m_pad(32'h0BAD_F00D, 0));
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      blank_count = 8'd16; blank_valid = 1'b1;
      #1;
      n_checks++;
      if (blank_ready !== 1'b1) begin n_fail++; $display("FAIL abort_blank_ready got=%b exp=1", blank_ready); end
      step();
      blank_valid = 1'b0;
      step();
      s = m_state;
      for (int r = 0; r < 4; r++) s = m_round(s, 33'h1);
      n_checks++;
      if (dut.reg_state_q !== s) begin n_fail++; $display("FAIL abort_mid_state got=%h exp=%h", dut.reg_state_q, s); end
      init = 1'b1;
      step();
      init = 1'b0;
      m_state = '0;
      n_checks++;
      if (blank_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle got=%b exp=1", blank_ready); end
      n_checks++;
      if (din_ready !== (DEPTH > 1)) begin n_fail++; $display("FAIL abort_din_ready got=%b exp=%b", din_ready, DEPTH > 1); end
      n_checks++;
      if (dut.reg_state_q !== m_state) begin n_fail++; $display("FAIL abort_state got=%h exp=0", dut.reg_state_q); end
      n_checks++;
      if ({dout_valid, dout_size, dout} !== {1'b1, 12'h020, exp_d}) begin
         n_fail++; $display("FAIL abort_kept got=%b/%h/%h exp=1/020/%h", dout_valid, dout_size, dout, exp_d);
      end
      dout_ready = 1'b1;
      step();
      n_checks++;
      if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL abort_pop got=%b exp=0", dout_valid); end
   endtask

   initial begin
      begin
         int p;
         p = 1;
         for (int j = 0; j < 33; j++) begin
            pos[j] = p;
            for (int k = 0; k < 4; k++) p = (p * 12) % 257;
         end
      end
      arstn = 1'b0; init = 1'b0; oper = 2'b00; enable_round = '0; din = '0; din_size = '0;
      din_valid = 1'b0; blank_count = '0; blank_valid = 1'b0; dout_ready = 1'b1;
      m_state = '0;
      test_reset();
      test_blank(8, 2);
      test_blank(0, 1);
      test_blank(5, 2);
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_init_abort();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
